imem_loader: RTL and testbench

Boot-time program loader that sits between an external byte source and the core's instruction memory. It receives a framed byte stream (length, instruction words, checksum) over a valid/ready handshake and writes each assembled 16-bit instruction into instruction memory. It holds the core in reset until a load completes with a correct checksum. It is the write-side counterpart of the simulation bench, which only observes the core: it places the program that the core will later fetch and execute.

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and status signals between the boot loader and its environment.
// The loader uses the slave modport; a byte source / test environment uses master.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [15:0]           imem_wdata;
  logic                  cpu_reset;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH:0]   words_loaded;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata,
           cpu_reset, busy, done, error, words_loaded
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata,
           cpu_reset, busy, done, error, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a length/words/checksum byte frame, writes 16-bit words into
// instruction memory and releases the core from reset only after a load with a good checksum.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [7:0]            runXor_q, runXor_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            hiByte_q, hiByte_d;
  logic [ADDR_WIDTH:0]   wordCount_q, wordCount_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  inReady_q, busy_q, done_q, error_q, cpuReset_q;

  logic                  accept;
  logic [15:0]           lenNew;
  logic [16:0]           wordsNext;
  logic                  busyNext;

  assign accept    = bus.in_valid && inReady_q;
  assign lenNew    = {len_q[15:8], bus.in_data};
  assign wordsNext = 17'(wordCount_q) + 17'd1;

  always_comb begin
    state_d     = state_q;
    runXor_d    = accept ? (runXor_q ^ bus.in_data) : runXor_q;
    len_d       = len_q;
    hiByte_d    = hiByte_q;
    wordCount_d = wordCount_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          state_d     = S_LEN_HI;
          runXor_d    = '0;
          wordCount_d = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = bus.in_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = lenNew;
          // A program larger than the memory is rejected before any byte of it is consumed
          if ({1'b0, lenNew} > CAPACITY) begin
            state_d = S_ERROR;
          end else if (lenNew == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hiByte_d = bus.in_data;
          state_d  = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          we_d        = 1'b1;
          addr_d      = wordCount_q[ADDR_WIDTH-1:0];
          wdata_d     = {hiByte_q, bus.in_data};
          wordCount_d = wordsNext[ADDR_WIDTH:0];
          state_d     = (wordsNext == {1'b0, len_q}) ? S_CHECK : S_DATA_HI;
        end
      end
      S_CHECK: begin
        if (accept) begin
          state_d = (bus.in_data == runXor_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busyNext = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA_HI) ||
                    (state_d == S_DATA_LO) || (state_d == S_CHECK);

  // Status flags are registered from the next state so every output comes straight from a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      runXor_q    <= '0;
      len_q       <= '0;
      hiByte_q    <= '0;
      wordCount_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      inReady_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpuReset_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      runXor_q    <= runXor_d;
      len_q       <= len_d;
      hiByte_q    <= hiByte_d;
      wordCount_q <= wordCount_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      inReady_q   <= busyNext;
      busy_q      <= busyNext;
      done_q      <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERROR);
      cpuReset_q  <= (state_d != S_DONE);
    end
  end

  assign bus.in_ready     = inReady_q;
  assign bus.imem_we      = we_q;
  assign bus.imem_addr    = addr_q;
  assign bus.imem_wdata   = wdata_q;
  assign bus.cpu_reset    = cpuReset_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.words_loaded = wordCount_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the test plan plus random frames,
// each judged by a frame-level reference model of the expected writes and final status.
module tb_imem_loader;

  localparam int AW = 8;
  localparam int ACCEPT_LIMIT = 100;

  logic clk;
  logic rst_n;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  frame[$];
  logic [7:0]  gotAddr[$];
  logic [15:0] gotData[$];
  logic        prevWe = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Capture every memory write; a strobe seen on two consecutive cycles is a width error
  always @(negedge clk) begin
    if (bus.imem_we) begin
      checkOutput("weOneCycle", 32'(prevWe), 32'd0);
      gotAddr.push_back(bus.imem_addr);
      gotData.push_back(bus.imem_wdata);
    end
    prevWe = bus.imem_we;
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".inReady"}, 32'(bus.in_ready), 32'd0);
    checkOutput({tag, ".we"}, 32'(bus.imem_we), 32'd0);
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, ".done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, ".error"}, 32'(bus.error), 32'd0);
    checkOutput({tag, ".cpuReset"}, 32'(bus.cpu_reset), 32'd1);
    checkOutput({tag, ".addr"}, 32'(bus.imem_addr), 32'd0);
    checkOutput({tag, ".wdata"}, 32'(bus.imem_wdata), 32'd0);
    checkOutput({tag, ".words"}, 32'(bus.words_loaded), 32'd0);
  endtask

  task automatic sendByte(input logic [7:0] b, input int gapMin, input int gapMax, input bit pulseStart);
    int gap;
    int waited;
    gap = $urandom_range(gapMax, gapMin);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.start    = (pulseStart && i == 0);
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    waited = 0;
    while (!bus.in_ready && waited < ACCEPT_LIMIT) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput("acceptTimeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic pulseStartIdle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    checkOutput("startBusy", 32'(bus.busy), 32'd1);
    checkOutput("startCpuReset", 32'(bus.cpu_reset), 32'd1);
    checkOutput("startDone", 32'(bus.done), 32'd0);
    checkOutput("startError", 32'(bus.error), 32'd0);
    checkOutput("startWords", 32'(bus.words_loaded), 32'd0);
  endtask

  // Reference model: derive the outcome of the whole frame from the framing rules
  task automatic checkResult();
    int n;
    int expWords;
    bit ok;
    logic [7:0] x;
    n = int'({frame[0], frame[1]});
    if (n > (1 << AW)) begin
      expWords = 0;
      ok = 1'b0;
    end else begin
      x = 8'h00;
      for (int i = 0; i < 2 * n + 2; i++) x ^= frame[i];
      ok = (frame[2 * n + 2] == x);
      expWords = n;
    end
    checkOutput("writeCount", 32'(gotAddr.size()), 32'(expWords));
    for (int k = 0; k < expWords && k < gotAddr.size(); k++) begin
      checkOutput("wrAddr", 32'(gotAddr[k]), 32'(k));
      checkOutput("wrData", 32'(gotData[k]), 32'({frame[2 + 2 * k], frame[3 + 2 * k]}));
    end
    if (expWords > 0) begin
      checkOutput("addrHold", 32'(bus.imem_addr), 32'(expWords - 1));
    end
    checkOutput("done", 32'(bus.done), 32'(ok));
    checkOutput("error", 32'(bus.error), 32'(!ok));
    checkOutput("cpuReset", 32'(bus.cpu_reset), 32'(!ok));
    checkOutput("busyEnd", 32'(bus.busy), 32'd0);
    checkOutput("readyEnd", 32'(bus.in_ready), 32'd0);
    checkOutput("wordsLoaded", 32'(bus.words_loaded), 32'(expWords));
  endtask

  task automatic applyStimulus(input int gapMin, input int gapMax, input bit pulseStart);
    gotAddr.delete();
    gotData.delete();
    pulseStartIdle();
    for (int i = 0; i < frame.size(); i++) sendByte(frame[i], gapMin, gapMax, pulseStart);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkResult();
  endtask

  task automatic buildFrame(input int n, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    if (n <= (1 << AW)) begin
      for (int i = 0; i < 2 * n; i++) begin
        b = 8'($urandom);
        frame.push_back(b);
      end
      x = 8'h00;
      foreach (frame[i]) x ^= frame[i];
      if (corrupt) x ^= 8'($urandom_range(255, 1));
      frame.push_back(x);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkResetValues("resetHeld");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkResetValues("idleAfterReset");

    $display("[TB] good load");
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    applyStimulus(0, 0, 1'b0);

    $display("[TB] bad checksum then recovery");
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    applyStimulus(0, 0, 1'b0);
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    applyStimulus(0, 0, 1'b0);

    $display("[TB] length overflow");
    frame = '{8'h01, 8'h01};
    applyStimulus(0, 0, 1'b0);

    $display("[TB] empty program");
    frame = '{8'h00, 8'h00, 8'h00};
    applyStimulus(0, 0, 1'b0);

    $display("[TB] gaps with mid-session start");
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    applyStimulus(1, 1, 1'b1);

    $display("[TB] full-capacity program");
    buildFrame(1 << AW, 1'b0);
    applyStimulus(0, 0, 1'b0);

    $display("[TB] reset mid-session");
    gotAddr.delete();
    gotData.delete();
    pulseStartIdle();
    sendByte(8'h00, 0, 0, 1'b0);
    sendByte(8'h02, 0, 0, 1'b0);
    sendByte(8'h12, 0, 0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkResetValues("midReset");
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h34;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    checkResetValues("idleAfterMidReset");
    checkOutput("midResetWrites", 32'(gotAddr.size()), 32'd0);

    $display("[TB] random frames");
    for (int t = 0; t < 24; t++) begin
      int r;
      int n;
      r = $urandom_range(9, 0);
      if (r == 0) n = (1 << AW) + 1 + $urandom_range(2000, 0);
      else if (r == 1) n = 0;
      else n = $urandom_range(8, 1);
      buildFrame(n, ($urandom_range(3, 0) == 0));
      applyStimulus(0, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
